// File: rtl/fetch_pc_stage.sv
// fetch_pc_stage: owns the PC, issues word fetches to imem, buffers returned words (2 entries) toward decode.
// Latency: request granted at N -> response at N+1 -> head visible at N+2; a redirect yields a valid head 3 cycles later.
// Backpressure: fetch issue stalls while buffered + in-flight words (less this cycle's pop) reach 2; decode pops via valid/ready.
//
// Ports:
//   clk_in, reset_in (sync, active-high)      clock and reset
//   redirect_in, redirect_pc_in               PC redirect strobe and target (target bits [1:0] ignored)
//   imem_req_out, imem_addr_out, imem_gnt_in  fetch request / address / accept
//   imem_rdata_in                             instruction word, valid one cycle after a grant
//   inst_valid_out, inst_out, inst_pc_out     buffer head toward decode
//   inst_ready_in                             decode accepts the head
//   perf_fetch_cnt_out, perf_stall_cnt_out    only when FETCH_PERF_CNT_EN is defined
//
// Optional feature macro: FETCH_PERF_CNT_EN (pop counter and grant-stall counter).
module fetch_pc_stage #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic              redirect_in,
  input  logic [ADDR_W-1:0] redirect_pc_in,
  output logic              imem_req_out,
  output logic [ADDR_W-1:0] imem_addr_out,
  input  logic              imem_gnt_in,
  input  logic [DATA_W-1:0] imem_rdata_in,
  output logic              inst_valid_out,
  output logic [DATA_W-1:0] inst_out,
  output logic [ADDR_W-1:0] inst_pc_out,
  input  logic              inst_ready_in
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetch_cnt_out,
  output logic [31:0]       perf_stall_cnt_out
`endif
);

  // PCs are held as word addresses; the byte offset is always zero.
  localparam int WA_W = ADDR_W - 2;
  localparam logic [WA_W-1:0] WA_ONE = {{(WA_W-1){1'b0}}, 1'b1};

  logic [WA_W-1:0]   r_pc;
  logic [WA_W-1:0]   r_req_pc;
  logic              r_inflight;
  logic              r_kill;
  logic [DATA_W-1:0] r_buf_dat [2];
  logic [WA_W-1:0]   r_buf_pc  [2];
  logic              r_rd_ptr;
  logic              r_wr_ptr;
  logic [1:0]        r_count;

  logic              w_vld;
  logic              w_pop;
  logic              w_push;
  logic              w_req;
  logic              w_gnt;
  logic [2:0]        w_occ;
  logic              w_unused_ok;

  assign w_unused_ok = ^redirect_pc_in[1:0];

  assign w_vld  = (r_count != 2'd0);
  assign w_pop  = w_vld & inst_ready_in;

  // Occupancy seen by the issue check: buffered + in flight, minus the slot freed by this cycle's pop.
  // count == 0 implies no pop, so the subtraction never underflows.
  assign w_occ  = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_req  = ~reset_in & ~redirect_in & (w_occ < 3'd2);
  assign w_gnt  = w_req & imem_gnt_in;

  // A response is captured only if it was not cancelled by a redirect (this cycle or the previous one) or reset.
  assign w_push = r_inflight & ~r_kill & ~redirect_in & ~reset_in;

  assign imem_req_out   = w_req;
  assign imem_addr_out  = {r_pc, 2'b00};
  assign inst_valid_out = w_vld;
  // Head is gated so an empty buffer always presents zeros.
  assign inst_out       = w_vld ? r_buf_dat[r_rd_ptr] : '0;
  assign inst_pc_out    = w_vld ? {r_buf_pc[r_rd_ptr], 2'b00} : '0;

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_pc       <= RESET_PC[ADDR_W-1:2];
      r_req_pc   <= '0;
      r_inflight <= 1'b0;
      r_kill     <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_wr_ptr   <= 1'b0;
      r_count    <= 2'd0;
    end else if (redirect_in) begin
      // Redirect outranks grant, push and pop: flush and retarget.
      r_pc       <= redirect_pc_in[ADDR_W-1:2];
      r_inflight <= 1'b0;
      r_kill     <= r_inflight;
      r_rd_ptr   <= 1'b0;
      r_wr_ptr   <= 1'b0;
      r_count    <= 2'd0;
    end else begin
      r_kill     <= 1'b0;
      r_inflight <= w_gnt;
      if (w_gnt) begin
        r_pc     <= r_pc + WA_ONE;
        r_req_pc <= r_pc;
      end
      if (w_push) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  // Buffer storage carries no reset; validity comes from r_count.
  always_ff @(posedge clk_in) begin
    if (w_push) begin
      r_buf_dat[r_wr_ptr] <= imem_rdata_in;
      r_buf_pc[r_wr_ptr]  <= r_req_pc;
    end
  end

  // Issue gating keeps count + inflight <= 2, so a push never meets a full buffer.
  assert property (@(posedge clk_in) disable iff (reset_in) !(w_push && (r_count == 2'd2)));

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_perf_fetch;
  logic [31:0] r_perf_stall;

  // Neither counter is cleared by a redirect; both wrap naturally.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_perf_fetch <= 32'd0;
      r_perf_stall <= 32'd0;
    end else begin
      if (w_pop) begin
        r_perf_fetch <= r_perf_fetch + 32'd1;
      end
      if (w_req & ~imem_gnt_in) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
    end
  end

  assign perf_fetch_cnt_out = r_perf_fetch;
  assign perf_stall_cnt_out = r_perf_stall;
`endif

endmodule

// File: tb/tb_fetch_pc_stage.sv
// tb_fetch_pc_stage: bench for fetch_pc_stage with a transaction-level reference model.
// Latency: model predicts head visibility two cycles after each grant.
// Backpressure: inst_ready_in and imem_gnt_in are driven by vectors and at random.
module tb_fetch_pc_stage;

  localparam logic [31:0] K   = 32'hA5A5_A5A5;
  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_in, redirect_in, imem_gnt_in, inst_ready_in;
  logic [31:0] redirect_pc_in;
  logic        imem_req_out, inst_valid_out;
  logic [31:0] imem_addr_out, imem_rdata_in, inst_out, inst_pc_out;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt_out, perf_stall_cnt_out;
`endif

  fetch_pc_stage #(.ADDR_W(32), .DATA_W(32), .RESET_PC(RPC)) dut (
    .clk_in         (clk),
    .reset_in       (reset_in),
    .redirect_in    (redirect_in),
    .redirect_pc_in (redirect_pc_in),
    .imem_req_out   (imem_req_out),
    .imem_addr_out  (imem_addr_out),
    .imem_gnt_in    (imem_gnt_in),
    .imem_rdata_in  (imem_rdata_in),
    .inst_valid_out (inst_valid_out),
    .inst_out       (inst_out),
    .inst_pc_out    (inst_pc_out),
    .inst_ready_in  (inst_ready_in)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt_out (perf_fetch_cnt_out),
    .perf_stall_cnt_out (perf_stall_cnt_out)
`endif
  );

  // Instruction memory: word = address ^ K one cycle after a grant, garbage otherwise.
  always @(posedge clk) begin
    if (imem_req_out && imem_gnt_in) imem_rdata_in <= imem_addr_out ^ K;
    else                             imem_rdata_in <= $urandom;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: a queue of fetched-but-undelivered words, each with the cycle it becomes visible.
  typedef struct { logic [31:0] pc; int vis; } ent_t;
  ent_t        m_q[$];
  logic [31:0] m_pc;
  bit          m_known = 1'b0;
  int          m_cyc = 0;
  logic [31:0] m_fetch = 32'd0;
  logic [31:0] m_stall = 32'd0;

  task automatic model_step();
    bit ev, pop, er;
    ev  = (m_q.size() > 0) && (m_q[0].vis <= m_cyc);
    pop = ev && inst_ready_in;
    er  = !reset_in && !redirect_in && ((m_q.size() - int'(pop)) < 2);
    if (m_known || reset_in) check("m_req", 32'(imem_req_out), 32'(er));
    if (m_known) begin
      check("m_valid", 32'(inst_valid_out), 32'(ev));
      if (er) check("m_addr", imem_addr_out, m_pc);
      if (ev) begin
        check("m_pc", inst_pc_out, m_q[0].pc);
        check("m_inst", inst_out, m_q[0].pc ^ K);
      end
`ifdef FETCH_PERF_CNT_EN
      check("m_perf_fetch", perf_fetch_cnt_out, m_fetch);
      check("m_perf_stall", perf_stall_cnt_out, m_stall);
`endif
    end
    if (reset_in) begin
      m_q.delete();
      m_pc    = RPC;
      m_known = 1'b1;
      m_fetch = 32'd0;
      m_stall = 32'd0;
    end else begin
      if (pop) begin
        void'(m_q.pop_front());
        m_fetch = m_fetch + 32'd1;
      end
      if (er && !imem_gnt_in) m_stall = m_stall + 32'd1;
      if (redirect_in) begin
        m_q.delete();
        m_pc = redirect_pc_in & ~32'h3;
      end else if (er && imem_gnt_in) begin
        m_q.push_back('{m_pc, m_cyc + 2});
        m_pc = m_pc + 32'd4;
      end
    end
    m_cyc++;
  endtask

  task automatic drv(input logic rst, input logic redir, input logic [31:0] rpc,
                     input logic gnt, input logic rdy);
    reset_in       = rst;
    redirect_in    = redir;
    redirect_pc_in = rpc;
    imem_gnt_in    = gnt;
    inst_ready_in  = rdy;
  endtask

  task automatic negx();
    @(negedge clk);
    model_step();
  endtask

  task automatic posx();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic e_req, input logic [31:0] e_addr,
                         input logic e_vld, input logic [31:0] e_pc);
    check({tag, "_req"},   32'(imem_req_out),   32'(e_req));
    check({tag, "_addr"},  imem_addr_out,       e_addr);
    check({tag, "_valid"}, 32'(inst_valid_out), 32'(e_vld));
    check({tag, "_pc"},    inst_pc_out,         e_vld ? e_pc : 32'h0);
    check({tag, "_inst"},  inst_out,            e_vld ? (e_pc ^ K) : 32'h0);
  endtask

  typedef struct {
    logic        rst, gnt, rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_pc;
  } vec_t;
  vec_t tbl[12];

  initial begin
    // Reset fill, steady stream, then decode stall and release.
    tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h100, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h104, 1'b0, 32'h0};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h108, 1'b1, 32'h100};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h10C, 1'b1, 32'h104};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h110, 1'b1, 32'h108};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h110, 1'b1, 32'h108};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h110, 1'b1, 32'h108};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h110, 1'b1, 32'h108};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h114, 1'b1, 32'h10C};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h118, 1'b1, 32'h110};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h11C, 1'b1, 32'h114};

    drv(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    negx(); posx();

    for (int i = 0; i < 12; i++) begin
      drv(tbl[i].rst, 1'b0, 32'h0, tbl[i].gnt, tbl[i].rdy);
      negx();
      chk_out($sformatf("tbl%0d", i), tbl[i].e_req, tbl[i].e_addr, tbl[i].e_vld, tbl[i].e_pc);
      posx();
    end

    // Redirect to 0x20, then three ungranted cycles hold the address.
    drv(1'b0, 1'b1, 32'h20, 1'b1, 1'b1);
    negx(); chk_out("redir20", 1'b0, 32'h120, 1'b1, 32'h118); posx();
    drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      negx(); chk_out($sformatf("stall%0d", i), 1'b1, 32'h20, 1'b0, 32'h0); posx();
    end
    drv(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    negx(); chk_out("gnt20", 1'b1, 32'h20, 1'b0, 32'h0); posx();
    negx(); chk_out("gnt24", 1'b1, 32'h24, 1'b0, 32'h0); posx();

    // Redirect to 0x403 with one word buffered and one in flight.
    drv(1'b0, 1'b1, 32'h403, 1'b1, 1'b0);
    negx(); chk_out("redir403", 1'b0, 32'h28, 1'b1, 32'h20); posx();
    drv(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    negx(); chk_out("r403_n1", 1'b1, 32'h400, 1'b0, 32'h0); posx();
    negx(); chk_out("r403_n2", 1'b1, 32'h404, 1'b0, 32'h0); posx();
    negx(); chk_out("r403_n3", 1'b1, 32'h408, 1'b1, 32'h400); posx();

    // PC wrap at the top of the address space.
    drv(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1);
    negx(); chk_out("redirtop", 1'b0, 32'h40C, 1'b1, 32'h404); posx();
    drv(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    negx(); chk_out("wrap0", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0); posx();
    negx(); chk_out("wrap1", 1'b1, 32'h0, 1'b0, 32'h0); posx();
    negx(); chk_out("wrap2", 1'b1, 32'h4, 1'b1, 32'hFFFF_FFFC); posx();
    negx(); chk_out("wrap3", 1'b1, 32'h8, 1'b1, 32'h0); posx();

    // Back-to-back redirects: only the second target is fetched.
    drv(1'b0, 1'b1, 32'h800, 1'b1, 1'b1);
    negx(); chk_out("b2b_a", 1'b0, 32'hC, 1'b1, 32'h4); posx();
    drv(1'b0, 1'b1, 32'h900, 1'b1, 1'b1);
    negx(); chk_out("b2b_b", 1'b0, 32'h800, 1'b0, 32'h0); posx();
    drv(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    negx(); chk_out("b2b_1", 1'b1, 32'h900, 1'b0, 32'h0); posx();
    negx(); chk_out("b2b_2", 1'b1, 32'h904, 1'b0, 32'h0); posx();
    negx(); chk_out("b2b_3", 1'b1, 32'h908, 1'b1, 32'h900); posx();

    // Reset while a word is buffered and a response is in flight.
    drv(1'b0, 1'b1, 32'h40, 1'b1, 1'b0);
    negx(); chk_out("d_redir", 1'b0, 32'h90C, 1'b1, 32'h904); posx();
    drv(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    negx(); chk_out("d1", 1'b1, 32'h40, 1'b0, 32'h0); posx();
    negx(); chk_out("d2", 1'b1, 32'h44, 1'b0, 32'h0); posx();
    drv(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    negx(); chk_out("d_rst", 1'b0, 32'h48, 1'b1, 32'h40); posx();
    drv(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    negx(); chk_out("d_post1", 1'b1, 32'h100, 1'b0, 32'h0); posx();
    negx(); chk_out("d_post2", 1'b1, 32'h104, 1'b0, 32'h0); posx();
    negx(); chk_out("d_post3", 1'b1, 32'h108, 1'b1, 32'h100); posx();

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      drv(($urandom % 100) == 0, ($urandom % 12) == 0, $urandom,
          ($urandom % 4) != 0, ($urandom % 3) != 0);
      negx(); posx();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
